sysid_info_regs: RTL and testbench

SYSID_INFO_REGS -- requirements
Module: sysid_info_regs

---
 rtl/sysid_info_regs.sv | 136 +++++++++++++
 tb/tb_sysid_info_regs.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sysid_info_regs.sv
// System ID / build info register block on a zero-wait Avalon-MM slave.
// ID, build timestamp, 64-bit uptime counter with an atomic high-half shadow, and R/W scratch words.
module sysid_scratch_word (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] q_o
);
  logic [31:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (we_i) word_d = wdata_i;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) word_q <= '0;
    else          word_q <= word_d;
  end

  assign q_o = word_q;
endmodule

module sysid_info_regs #(
  parameter logic [31:0] ID_VALUE    = 32'd1459559916,
  parameter logic [31:0] TIMESTAMP   = 32'd0,
  parameter int          NUM_SCRATCH = 2,
  parameter int          ADDR_W      = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);
  localparam int STAGES = 1;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  req_t req;
  assign req = '{rd: read, wr: write, addr: address, wdata: writedata};

  // Full-width compares everywhere so upper address bits never alias.
  logic hit_id, hit_ts, hit_lo, hit_hi;
  assign hit_id = (req.addr == ADDR_W'(0));
  assign hit_ts = (req.addr == ADDR_W'(1));
  assign hit_lo = (req.addr == ADDR_W'(2));
  assign hit_hi = (req.addr == ADDR_W'(3));

  logic [NUM_SCRATCH-1:0]       scr_hit;
  logic [NUM_SCRATCH-1:0][31:0] scr_q;

  genvar g;
  generate
    for (g = 0; g < NUM_SCRATCH; g++) begin : g_scr
      assign scr_hit[g] = (req.addr == ADDR_W'(4 + g));
      sysid_scratch_word u_word (
        .clock   (clock),
        .reset_n (reset_n),
        .we_i    (req.wr && scr_hit[g]),
        .wdata_i (req.wdata),
        .q_o     (scr_q[g])
      );
    end
  endgenerate

  logic [63:0] cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;

  // A clear loads zero and the same edge's tick is still applied, so the
  // counter reads 1 on the following cycle, matching the post-reset behaviour.
  always_comb begin
    cnt_d = cnt_q + 64'd1;
    if (req.wr && hit_lo) cnt_d = 64'd1;
  end

  always_comb begin
    shadow_d = shadow_q;
    if (req.rd && hit_lo) shadow_d = cnt_q[63:32];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    if (hit_id) rd_mux = ID_VALUE;
    if (hit_ts) rd_mux = TIMESTAMP;
    if (hit_lo) rd_mux = cnt_q[31:0];
    if (hit_hi) rd_mux = shadow_q;
    for (int i = 0; i < NUM_SCRATCH; i++)
      if (scr_hit[i]) rd_mux = scr_q[i];
  end

  logic [31:0]       rdata_q, rdata_d;
  logic [STAGES:0]   vld_pipe;
  logic [STAGES:1]   vld_pipe_q;

  assign vld_pipe[0]        = req.rd;
  assign vld_pipe[STAGES:1] = vld_pipe_q;

  always_comb begin
    rdata_d = rdata_q;
    if (req.rd) rdata_d = rd_mux;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q    <= '0;
      vld_pipe_q <= '0;
    end else begin
      rdata_q    <= rdata_d;
      vld_pipe_q <= vld_pipe[STAGES-1:0];
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = vld_pipe[STAGES];
endmodule

// File: tb/tb_sysid_info_regs.sv
// Randomized + directed bench for sysid_info_regs against a register-map model.
module tb_sysid_info_regs;
  localparam logic [31:0] ID = 32'd1459559916;
  localparam logic [31:0] TS = 32'h5EED_1234;
  localparam int NS = 2;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          readdatavalid;

  sysid_info_regs #(.ID_VALUE(ID), .TIMESTAMP(TS), .NUM_SCRATCH(NS), .ADDR_W(AW)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference state: what the register map should hold, not how it is built.
  logic [63:0] m_cnt;
  logic [31:0] m_shadow;
  logic [31:0] m_scr [NS];
  logic [31:0] m_rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_cnt = '0;
    m_shadow = '0;
    for (int i = 0; i < NS; i++) m_scr[i] = '0;
    m_rdata = '0;
  endtask

  // One bus cycle: present inputs, let the edge happen, advance the model, check.
  task automatic cyc(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [31:0] wd);
    logic [31:0] exp;
    int ai;
    read = rd; write = wr; address = a; writedata = wd;
    @(posedge clock);
    ai = int'(a);
    exp = m_rdata;
    if (rd) begin
      if (ai == 0)                   exp = ID;
      else if (ai == 1)              exp = TS;
      else if (ai == 2)              begin exp = m_cnt[31:0]; m_shadow = m_cnt[63:32]; end
      else if (ai == 3)              exp = m_shadow;
      else if (ai >= 4 && ai < 4+NS) exp = m_scr[ai-4];
      else                           exp = '0;
    end
    if (wr && ai == 2) m_cnt = '0;
    if (wr && ai >= 4 && ai < 4+NS) m_scr[ai-4] = wd;
    m_cnt = m_cnt + 64'd1;
    m_rdata = exp;
    #1;
    chk("rdvalid", {63'd0, readdatavalid}, {63'd0, rd});
    chk("rdata", {32'd0, readdata}, {32'd0, exp});
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    m_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rdata", {32'd0, readdata}, 64'd0);
    chk("rst_rdv", {63'd0, readdatavalid}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // ID and timestamp back to back, latency 1
    cyc(1, 0, 0, 0);  chk("id_const", {32'd0, readdata}, {32'd0, ID});
    cyc(1, 0, 1, 0);  chk("ts_const", {32'd0, readdata}, {32'd0, TS});
    cyc(0, 0, 0, 0);
    chk("hold", {32'd0, readdata}, {32'd0, TS});

    // scratch write, read, and read-during-write
    cyc(0, 1, 4, 32'hDEADBEEF);
    cyc(1, 0, 4, 0);            chk("scr_wr", {32'd0, readdata}, 64'hDEADBEEF);
    cyc(1, 1, 4, 32'h12345678); chk("scr_rdw", {32'd0, readdata}, 64'hDEADBEEF);
    cyc(1, 0, 4, 0);            chk("scr_new", {32'd0, readdata}, 64'h12345678);

    // 32-bit carry into the high half, snapshot via shadow
    @(negedge clock);
    dut.cnt_q = 64'h0000_0001_FFFF_FFFF;
    m_cnt     = 64'h0000_0001_FFFF_FFFF;
    cyc(1, 0, 2, 0); chk("lo_wrap", {32'd0, readdata}, 64'hFFFFFFFF);
    cyc(1, 0, 3, 0); chk("hi_shadow", {32'd0, readdata}, 64'h1);
    repeat (5) cyc(0, 0, 0, 0);
    cyc(1, 0, 3, 0); chk("hi_stable", {32'd0, readdata}, 64'h1);

    // clear then read 5 cycles later
    cyc(0, 1, 2, 32'hFFFF_FFFF);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(1, 0, 2, 0); chk("clr5", {32'd0, readdata}, 64'd5);
    cyc(1, 0, 3, 0); chk("clr_hi", {32'd0, readdata}, 64'd0);

    // unmapped read, ignored ID write, aliasing address
    cyc(1, 1, 0, 32'h0BAD_0BAD); chk("id_wr_rdw", {32'd0, readdata}, {32'd0, ID});
    cyc(1, 0, 7, 0);             chk("unmapped", {32'd0, readdata}, 64'd0);
    cyc(1, 0, 0, 0);             chk("id_kept", {32'd0, readdata}, {32'd0, ID});
    cyc(0, 1, 12, 32'hA5A5_A5A5);
    cyc(1, 0, 4, 0);             chk("no_alias", {32'd0, readdata}, 64'h12345678);

    // randomized traffic
    for (int n = 0; n < 400; n++)
      cyc(logic'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
          AW'($urandom_range(0, 15)), $urandom);

    // reset mid read burst
    cyc(0, 1, 5, 32'hCAFE_F00D);
    cyc(1, 0, 5, 0);
    read = 1'b1; address = 4;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_rdv", {63'd0, readdatavalid}, 64'd0);
    chk("arst_rdata", {32'd0, readdata}, 64'd0);
    m_reset();
    @(posedge clock);
    #1;
    chk("rst_hold_rdv", {63'd0, readdatavalid}, 64'd0);
    read = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    cyc(1, 0, 2, 0); chk("cnt_restart", {32'd0, readdata}, 64'd0);
    cyc(1, 0, 5, 0); chk("scr_cleared", {32'd0, readdata}, 64'd0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 2, 0); chk("cnt_run", {32'd0, readdata}, 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
